// File: rtl/ring_sweep_pkg.sv
// Shared types and helpers for the ring-oscillator sweep sequencer.
// Ring index k (0 = ring 005 ... 5 = ring 197) maps to select bit (NUM_RINGS-1-k).
package ring_sweep_pkg;

  localparam int NUM_RINGS = 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_SELECT,
    ST_GATE,
    ST_REPORT,
    ST_DONE
  } state_t;

  typedef struct packed {
    logic       found;
    logic [2:0] idx;
  } bit_search_t;

  function automatic logic [NUM_RINGS-1:0] idx_to_sel(input logic [2:0] idx);
    logic [NUM_RINGS-1:0] sel;
    sel = '0;
    for (int k = 0; k < NUM_RINGS; k++) begin
      if (idx == 3'(k)) sel[NUM_RINGS-1-k] = 1'b1;
    end
    return sel;
  endfunction

  // Lowest set bit of mask at or above position 'from'; 'from' may be NUM_RINGS (nothing left).
  function automatic bit_search_t next_set_bit(input logic [NUM_RINGS-1:0] mask,
                                               input logic [3:0]           from);
    bit_search_t res;
    res = '0;
    for (int k = NUM_RINGS - 1; k >= 0; k--) begin
      if (mask[k] && (4'(k) >= from)) begin
        res.found = 1'b1;
        res.idx   = 3'(k);
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/ring_edge_sync.sv
// Brings the asynchronous ring output into the i_clk domain and emits a one-cycle
// pulse per rising edge. Only meaningful for ring frequencies below i_clk/2.
module ring_edge_sync (
  input  logic i_clk,
  input  logic i_rst,
  input  logic i_async,
  output logic o_pulse
);

  logic meta_d, meta_q;
  logic sync_d, sync_q;
  logic prev_d, prev_q;

  always_comb begin
    meta_d = i_async;
    sync_d = meta_q;
    prev_d = sync_q;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      meta_q <= meta_d;
      sync_q <= sync_d;
      prev_q <= prev_d;
    end
  end

  assign o_pulse = sync_q & ~prev_q;

endmodule

// File: rtl/ring_sweep.sv
// Ring-oscillator measurement sequencer: select each enabled ring, settle, count edges over a gate.
// Define RING_SWEEP_CONT_EN for continuous sweeping; then i_start while busy stops after the current report.
module ring_sweep
  import ring_sweep_pkg::*;
#(
  parameter int pGATE_LOG2 = 10,
  parameter int pSETTLE    = 16,
  parameter int pCNT_W     = 16
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [5:0]        i_mask,
  output logic [5:0]        o_sel,
  input  logic              i_ring,
  output logic              o_busy,
  output logic              o_valid,
  input  logic              i_ready,
  output logic [2:0]        o_idx,
  output logic [pCNT_W-1:0] o_count,
  output logic              o_done
);

  localparam int GATE_LEN = 1 << pGATE_LOG2;
  localparam int SETTLE_W = $clog2(pSETTLE + 1);
  localparam int TMR_W    = ((pGATE_LOG2 > SETTLE_W) ? pGATE_LOG2 : SETTLE_W) + 1;

  state_t              state_d, state_q;
  logic [2:0]          idx_d, idx_q;
  logic [5:0]          mask_d, mask_q;
  logic [TMR_W-1:0]    tmr_d, tmr_q;
  logic [pCNT_W-1:0]   cnt_d, cnt_q;
  logic [5:0]          sel_d, sel_q;
  logic                busy_d, busy_q;
  logic                valid_d, valid_q;
  logic                done_d, done_q;

  logic                edge_pulse;
  logic                stop_req;
  bit_search_t         start_bit;
  bit_search_t         later_bit;

  ring_edge_sync u_edge_sync (
    .i_clk   (i_clk),
    .i_rst   (i_rst),
    .i_async (i_ring),
    .o_pulse (edge_pulse)
  );

  assign start_bit = next_set_bit(i_mask, 4'd0);
  assign later_bit = next_set_bit(mask_q, {1'b0, idx_q} + 4'd1);

`ifdef RING_SWEEP_CONT_EN
  logic        stop_d, stop_q;
  bit_search_t first_bit;

  assign first_bit = next_set_bit(mask_q, 4'd0);
  assign stop_req  = stop_q | i_start;

  always_comb begin
    stop_d = (state_q == ST_IDLE) ? 1'b0 : stop_req;
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) stop_q <= 1'b0;
    else       stop_q <= stop_d;
  end
`else
  assign stop_req = 1'b0;
`endif

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    mask_d  = mask_q;
    tmr_d   = tmr_q;
    cnt_d   = cnt_q;

    case (state_q)
      ST_IDLE: begin
        tmr_d = '0;
        if (i_start) begin
          mask_d = i_mask;
          if (start_bit.found) begin
            state_d = ST_SELECT;
            idx_d   = start_bit.idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      // o_sel lags the state by one cycle, so settling runs pSETTLE+1 state cycles.
      ST_SELECT: begin
        cnt_d = '0;
        if (tmr_q == TMR_W'(pSETTLE)) begin
          tmr_d   = '0;
          state_d = ST_GATE;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_GATE: begin
        if (edge_pulse && (cnt_q != {pCNT_W{1'b1}})) cnt_d = cnt_q + 1'b1;
        if (tmr_q == TMR_W'(GATE_LEN - 1)) begin
          tmr_d   = '0;
          state_d = ST_REPORT;
        end else begin
          tmr_d = tmr_q + 1'b1;
        end
      end
      ST_REPORT: begin
        if (valid_q && i_ready) begin
          if (later_bit.found && !stop_req) begin
            state_d = ST_SELECT;
            idx_d   = later_bit.idx;
          end else begin
            state_d = ST_DONE;
          end
        end
      end
      ST_DONE: begin
`ifdef RING_SWEEP_CONT_EN
        if (!stop_req && first_bit.found) begin
          state_d = ST_SELECT;
          idx_d   = first_bit.idx;
        end else begin
          state_d = ST_IDLE;
        end
`else
        state_d = ST_IDLE;
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    busy_d  = (state_q != ST_IDLE);
    sel_d   = (state_q inside {ST_SELECT, ST_GATE, ST_REPORT}) ? idx_to_sel(idx_q) : 6'b0;
    valid_d = (state_q == ST_REPORT) && !(valid_q && i_ready);
    done_d  = (state_q == ST_DONE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      mask_q  <= '0;
      tmr_q   <= '0;
      cnt_q   <= '0;
      sel_q   <= '0;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      mask_q  <= mask_d;
      tmr_q   <= tmr_d;
      cnt_q   <= cnt_d;
      sel_q   <= sel_d;
      busy_q  <= busy_d;
      valid_q <= valid_d;
      done_q  <= done_d;
    end
  end

  assign o_sel   = sel_q;
  assign o_busy  = busy_q;
  assign o_valid = valid_q;
  assign o_idx   = idx_q;
  assign o_count = cnt_q;
  assign o_done  = done_q;

endmodule

// File: tb/tb_ring_sweep.sv
// Directed bench for ring_sweep: a vector table of whole sweeps plus hand sequences for
// latency, zero mask, REPORT stall with saturation, reset mid-gate and (optionally) continuous mode.
module tb_ring_sweep;

  typedef struct packed {
    logic [5:0]  mask;
    logic [1:0]  ring_mode;
    logic [1:0]  n_res;
    logic [8:0]  idx_list;
    logic [17:0] sel_list;
    logic [7:0]  cnt;
    logic [1:0]  sat_cnt;
  } vec_t;

  logic       clk, rst, start, ring, ready;
  logic [5:0] mask;
  logic [1:0] ring_mode;

  logic [5:0] sel, s_sel;
  logic       busy, valid, done, s_busy, s_valid, s_done;
  logic [2:0] idx, s_idx;
  logic [7:0] count;
  logic [1:0] s_count;

  int n_checks = 0;
  int n_fail   = 0;
  vec_t vecs [5];

  ring_sweep #(.pGATE_LOG2(4), .pSETTLE(12), .pCNT_W(8)) dut (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mask(mask), .o_sel(sel), .i_ring(ring),
    .o_busy(busy), .o_valid(valid), .i_ready(ready), .o_idx(idx), .o_count(count), .o_done(done)
  );

  ring_sweep #(.pGATE_LOG2(4), .pSETTLE(12), .pCNT_W(2)) dut_sat (
    .i_clk(clk), .i_rst(rst), .i_start(start), .i_mask(mask), .o_sel(s_sel), .i_ring(ring),
    .o_busy(s_busy), .o_valid(s_valid), .i_ready(ready), .o_idx(s_idx), .o_count(s_count),
    .o_done(s_done)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Ring model: mode 1 toggles every clock (period 2), mode 2 every other clock (period 4), else low.
  initial begin
    int ph;
    ph   = 0;
    ring = 1'b0;
    forever begin
      @(posedge clk);
      #3;
      case (ring_mode)
        2'd1: ring = ~ring;
        2'd2: begin
          ph = ph + 1;
          if (ph >= 2) begin
            ring = ~ring;
            ph   = 0;
          end
        end
        default: ring = 1'b0;
      endcase
    end
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
    end
  endtask

  // Waits for o_done; in continuous builds the last handshake also carries a stop request.
  task automatic drainSweep(input int bound, output int dones);
    dones = 0;
    for (int c = 0; c < bound && dones == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
`ifdef RING_SWEEP_CONT_EN
      if (valid && ready) start = 1'b1;
`endif
      if (done) dones++;
    end
  endtask

  // Runs one whole sweep with i_ready high and compares every result against the vector.
  task automatic applyStimulus(input vec_t v);
    int got, dones, s_dones;
    got     = 0;
    dones   = 0;
    s_dones = 0;
    @(negedge clk);
    mask      = v.mask;
    ring_mode = v.ring_mode;
    ready     = 1'b1;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    mask  = ~v.mask;
    for (int c = 0; c < 400 && dones == 0; c++) begin
      @(negedge clk);
      start = 1'b0;
      if (valid) begin
        if (got < int'(v.n_res)) begin
          checkOutput("result idx", 32'(idx), 32'(v.idx_list[3*got +: 3]));
          checkOutput("result sel", 32'(sel), 32'(v.sel_list[6*got +: 6]));
          checkOutput("result count", 32'(count), 32'(v.cnt));
          checkOutput("sat valid", 32'(s_valid), 32'd1);
          checkOutput("sat idx", 32'(s_idx), 32'(v.idx_list[3*got +: 3]));
          checkOutput("sat sel", 32'(s_sel), 32'(v.sel_list[6*got +: 6]));
          checkOutput("sat count", 32'(s_count), 32'(v.sat_cnt));
        end
        got++;
`ifdef RING_SWEEP_CONT_EN
        if (got == int'(v.n_res)) start = 1'b1;
`endif
      end
      if (done) dones++;
      if (s_done) s_dones++;
    end
    checkOutput("result total", 32'(got), 32'(v.n_res));
    checkOutput("done pulses", 32'(dones), 32'd1);
    checkOutput("sat done pulses", 32'(s_dones), 32'd1);
    @(negedge clk);
    checkOutput("busy after sweep", 32'(busy), 32'd0);
    checkOutput("sat busy after sweep", 32'(s_busy), 32'd0);
    checkOutput("sel after sweep", 32'(sel), 32'd0);
    checkOutput("done width", 32'(done), 32'd0);
  endtask

  initial begin
    int dones, lat, seen;
    rst       = 1'b1;
    start     = 1'b0;
    mask      = 6'b0;
    ready     = 1'b1;
    ring_mode = 2'd0;

    vecs[0] = '{6'b000001, 2'd2, 2'd1, {3'd0, 3'd0, 3'd0},
                {6'b000000, 6'b000000, 6'b100000}, 8'd4, 2'd3};
    vecs[1] = '{6'b100101, 2'd2, 2'd3, {3'd5, 3'd2, 3'd0},
                {6'b000001, 6'b001000, 6'b100000}, 8'd4, 2'd3};
    vecs[2] = '{6'b000000, 2'd2, 2'd0, 9'd0, 18'd0, 8'd0, 2'd0};
    vecs[3] = '{6'b010000, 2'd1, 2'd1, {3'd0, 3'd0, 3'd4},
                {6'b000000, 6'b000000, 6'b000010}, 8'd8, 2'd3};
    vecs[4] = '{6'b000110, 2'd0, 2'd2, {3'd0, 3'd2, 3'd1},
                {6'b000000, 6'b001000, 6'b010000}, 8'd0, 2'd0};

    repeat (3) @(negedge clk);
    checkOutput("reset sel", 32'(sel), 32'd0);
    checkOutput("reset busy", 32'(busy), 32'd0);
    checkOutput("reset valid", 32'(valid), 32'd0);
    checkOutput("reset idx", 32'(idx), 32'd0);
    checkOutput("reset count", 32'(count), 32'd0);
    checkOutput("reset done", 32'(done), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    $display("[TB] latency sequence");
    mask      = 6'b000001;
    ring_mode = 2'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("sel one cycle after start", 32'(sel), 32'd0);
    @(negedge clk);
    checkOutput("sel two cycles after start", 32'(sel), 32'b100000);
    checkOutput("busy during sweep", 32'(busy), 32'd1);
    lat = 1;
    for (int c = 0; c < 100 && !valid; c++) begin
      @(negedge clk);
      lat++;
    end
    checkOutput("sel to valid latency", 32'(lat), 32'd30);
    checkOutput("latency count", 32'(count), 32'd4);
`ifdef RING_SWEEP_CONT_EN
    start = 1'b1;
`endif
    drainSweep(100, dones);
    checkOutput("latency sweep done", 32'(dones), 32'd1);
    @(negedge clk);

    $display("[TB] vector table");
    for (int i = 0; i < 5; i++) applyStimulus(vecs[i]);

    $display("[TB] zero mask timing");
    @(negedge clk);
    mask  = 6'b000000;
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    checkOutput("zero mask done early", 32'(done), 32'd0);
    @(negedge clk);
    checkOutput("zero mask done pulse", 32'(done), 32'd1);
    checkOutput("zero mask sel", 32'(sel), 32'd0);
    @(negedge clk);
    checkOutput("zero mask done end", 32'(done), 32'd0);
    checkOutput("zero mask valid", 32'(valid), 32'd0);

    $display("[TB] stall with saturation");
    @(negedge clk);
    mask      = 6'b010000;
    ring_mode = 2'd1;
    ready     = 1'b0;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 200 && !valid; c++) @(negedge clk);
    checkOutput("stall valid seen", 32'(valid), 32'd1);
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      checkOutput("stall valid", 32'(valid), 32'd1);
      checkOutput("stall count", 32'(count), 32'd8);
      checkOutput("stall sat count", 32'(s_count), 32'd3);
      checkOutput("stall sel", 32'(sel), 32'b000010);
    end
    ready = 1'b1;
`ifdef RING_SWEEP_CONT_EN
    start = 1'b1;
`endif
    drainSweep(20, dones);
    checkOutput("stall sweep done", 32'(dones), 32'd1);
    @(negedge clk);
    checkOutput("stall busy after", 32'(busy), 32'd0);

    $display("[TB] reset mid gate");
    mask      = 6'b000001;
    ring_mode = 2'd2;
    start     = 1'b1;
    @(negedge clk);
    start = 1'b0;
    for (int c = 0; c < 20 && sel == 6'b0; c++) @(negedge clk);
    repeat (18) @(negedge clk);
    checkOutput("mid gate sel", 32'(sel), 32'b100000);
    checkOutput("mid gate valid", 32'(valid), 32'd0);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    checkOutput("abort sel", 32'(sel), 32'd0);
    checkOutput("abort busy", 32'(busy), 32'd0);
    checkOutput("abort valid", 32'(valid), 32'd0);
    seen = 0;
    for (int c = 0; c < 60; c++) begin
      @(negedge clk);
      if (done || valid) seen++;
    end
    checkOutput("abort no done", 32'(seen), 32'd0);
    applyStimulus(vecs[0]);

`ifdef RING_SWEEP_CONT_EN
    begin
      int got, since;
      logic [11:0] seq;
      logic [7:0]  done_at;
      $display("[TB] continuous sweep");
      got     = 0;
      dones   = 0;
      since   = -1;
      seq     = '0;
      done_at = '0;
      @(negedge clk);
      mask      = 6'b000011;
      ring_mode = 2'd2;
      start     = 1'b1;
      @(negedge clk);
      start = 1'b0;
      for (int c = 0; c < 300; c++) begin
        @(negedge clk);
        start = 1'b0;
        if (since >= 0) since++;
        if (since == 5) start = 1'b1;
        if (valid) begin
          if (got < 4) seq[3*got +: 3] = idx;
          got++;
          if (got == 3) since = 0;
        end
        if (done) begin
          if (dones < 2) done_at[4*dones +: 4] = 4'(got);
          dones++;
        end
      end
      checkOutput("cont results", 32'(got), 32'd4);
      checkOutput("cont idx seq", 32'(seq), 32'({3'd1, 3'd0, 3'd1, 3'd0}));
      checkOutput("cont dones", 32'(dones), 32'd2);
      checkOutput("cont done positions", 32'(done_at), 32'({4'd4, 4'd2}));
      checkOutput("cont busy after stop", 32'(busy), 32'd0);
    end
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
